// File: rtl/clock_unit.sv
// rtl/clock_unit.sv - two reset-aligned divided clock waves plus a sticky lock flag
module clock_unit #(
    parameter int DIV0        = 2,
    parameter int DIV1        = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_clock0,
    output logic o_clock1,
    output logic o_valid
);

    localparam int W0 = (DIV0 > 2) ? $clog2(DIV0) : 1;
    localparam int W1 = (DIV1 > 2) ? $clog2(DIV1) : 1;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

    localparam logic [W0-1:0] HALF0 = W0'(DIV0 / 2);
    localparam logic [W0-1:0] LAST0 = W0'(DIV0 - 1);
    localparam logic [W1-1:0] HALF1 = W1'(DIV1 / 2);
    localparam logic [W1-1:0] LAST1 = W1'(DIV1 - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_PRE = LW'(LOCK_CYCLES - 1);

    generate
        if (DIV0 < 2) begin : g_bad_div0
            $error("clock_unit: DIV0 must be >= 2");
        end
        if (DIV1 < 2) begin : g_bad_div1
            $error("clock_unit: DIV1 must be >= 2");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("clock_unit: LOCK_CYCLES must be >= 1");
        end
    endgenerate

    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;
    logic [LW-1:0] lock_cnt;

    // Outputs compare the pre-increment count, so the first edge out of reset drives both high.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt0     <= '0;
            cnt1     <= '0;
            o_clock0 <= 1'b0;
            o_clock1 <= 1'b0;
        end else begin
            o_clock0 <= (cnt0 < HALF0);
            o_clock1 <= (cnt1 < HALF1);
            cnt0     <= (cnt0 == LAST0) ? '0 : cnt0 + 1'b1;
            cnt1     <= (cnt1 == LAST1) ? '0 : cnt1 + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lock_cnt <= '0;
            o_valid  <= 1'b0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == LOCK_PRE) begin
                o_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_unit.sv
// tb/tb_clock_unit.sv - directed vectors for clock_unit in three parameterisations
module tb_clock_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    logic a_c0, a_c1, a_v;
    logic b_c0, b_c1, b_v;
    logic c_c0, c_c1, c_v;

    clock_unit dut_a (.i_clock(clk), .i_reset(rst), .o_clock0(a_c0), .o_clock1(a_c1), .o_valid(a_v));
    clock_unit #(.DIV0(3), .DIV1(5), .LOCK_CYCLES(1)) dut_b (
        .i_clock(clk), .i_reset(rst), .o_clock0(b_c0), .o_clock1(b_c1), .o_valid(b_v));
    clock_unit #(.DIV0(6), .DIV1(2), .LOCK_CYCLES(16)) dut_c (
        .i_clock(clk), .i_reset(rst), .o_clock0(c_c0), .o_clock1(c_c1), .o_valid(c_v));

    typedef struct {
        logic rst;
        logic c0;
        logic c1;
        logic v;
    } vec_t;

    vec_t tbl[32];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] p0;
        logic [19:0] p1;
        logic [19:0] pv;
        int hi0, lo0, hi1, lo1, bcoin;

        // Post-release patterns, bit 0 = first edge: 1010..., 1100..., valid from the 16th edge
        p0 = 20'h55555;
        p1 = 20'h33333;
        pv = 20'hF8000;
        for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 20; k++) tbl[12 + k] = '{1'b0, p0[k], p1[k], pv[k]};

        for (int i = 0; i < 32; i++) begin
            rst = tbl[i].rst;
            step();
            chk("tbl_clock0", i, a_c0, tbl[i].c0);
            chk("tbl_clock1", i, a_c1, tbl[i].c1);
            chk("tbl_valid", i, a_v, tbl[i].v);
        end

        // Fresh reset, then 600 cycles = 100 periods of DIV0=6 on all three instances
        rst = 1'b1;
        step();
        chk("rst_b_clock0", 0, b_c0, 1'b0);
        chk("rst_b_valid", 0, b_v, 1'b0);
        chk("rst_c_clock0", 0, c_c0, 1'b0);
        rst = 1'b0;
        hi0 = 0; lo0 = 0; hi1 = 0; lo1 = 0; bcoin = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            chk("a_clock0", k, a_c0, (k % 2) == 0);
            chk("a_clock1", k, a_c1, (k % 4) < 2);
            chk("a_valid", k, a_v, k >= 15);
            chk("b_clock0", k, b_c0, (k % 3) == 0);
            chk("b_clock1", k, b_c1, (k % 5) < 2);
            chk("b_valid", k, b_v, 1'b1);
            chk("c_clock0", k, c_c0, (k % 6) < 3);
            chk("c_clock1", k, c_c1, (k % 2) == 0);
            chk("c_valid", k, c_v, k >= 15);
            if (c_c0) hi0++; else lo0++;
            if (c_c1) hi1++; else lo1++;
            if (b_c0 && b_c1 && (k % 3) == 0 && (k % 5) == 0) bcoin++;
        end
        chk("c_clock0_high_300", hi0, hi0 == 300, 1'b1);
        chk("c_clock0_low_300", lo0, lo0 == 300, 1'b1);
        chk("c_clock1_high_300", hi1, hi1 == 300, 1'b1);
        chk("c_clock1_low_300", lo1, lo1 == 300, 1'b1);
        chk("b_coincide_40", bcoin, bcoin == 40, 1'b1);

        // Edge 600: a_clock1 enters its high phase with valid set, then one-cycle reset
        step();
        chk("pre_rst_clock1", 600, a_c1, 1'b1);
        chk("pre_rst_valid", 600, a_v, 1'b1);
        rst = 1'b1;
        step();
        chk("mid_rst_a_clock0", 0, a_c0, 1'b0);
        chk("mid_rst_a_clock1", 0, a_c1, 1'b0);
        chk("mid_rst_a_valid", 0, a_v, 1'b0);
        chk("mid_rst_b_clock1", 0, b_c1, 1'b0);
        chk("mid_rst_b_valid", 0, b_v, 1'b0);
        chk("mid_rst_c_valid", 0, c_v, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("re_a_clock0", k, a_c0, p0[k]);
            chk("re_a_clock1", k, a_c1, p1[k]);
            chk("re_a_valid", k, a_v, pv[k]);
            chk("re_b_valid", k, b_v, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
